shift_reg_univ: RTL and testbench

Parametrised universal shift register: DEPTH stages of WIDTH bits each, with a synchronous active-high reset and enable. It supports hold, shift-up, shift-down and parallel-load modes, and tracks how many stages have been written since reset. It generalises the single-bit synchronous-reset flip-flop and serves as the team's generic storage/delay element for serialisers, delay lines and small data buffers.

---
 rtl/shift_reg_univ.sv | 39 +++
 tb/tb_shift_reg_univ.sv | 96 +++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: DEPTH x WIDTH universal shift register with hold, shift-up, shift-down, parallel load and a saturating fill count
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         sin,
  input  logic [WIDTH*DEPTH-1:0]   pin,
  output logic [WIDTH*DEPTH-1:0]   pout,
  output logic [WIDTH-1:0]         sout_up,
  output logic [WIDTH-1:0]         sout_dn,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                     full
);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [FW-1:0] FMAX = FW'(DEPTH);
  logic [WIDTH*DEPTH-1:0] q;
  logic [FW-1:0] fill_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= {DEPTH{RST_VAL}};
      fill_q <= '0;
    end else if (en && mode != 2'b00) begin
      q      <= mode == 2'b11 ? pin :
                mode == 2'b01 ? {q[WIDTH*(DEPTH-1)-1:0], sin} :
                                {sin, q[WIDTH*DEPTH-1:WIDTH]};
      fill_q <= (mode == 2'b11 || fill_q == FMAX) ? FMAX : fill_q + FW'(1);
    end
  end
  assign pout    = q;
  assign sout_up = q[WIDTH*(DEPTH-1) +: WIDTH];
  assign sout_dn = q[WIDTH-1:0];
  assign fill    = fill_q;
  assign full    = fill_q == FMAX;
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed stimulus feeding a scoreboard queue; a monitor compares DUT state against queued expectations
module tb_shift_reg_univ;
  logic        clk = 0;
  logic        rst = 0, en = 0;
  logic [1:0]  mode = 0;
  logic [7:0]  sin = 0;
  logic [31:0] pin = 0;
  logic [31:0] pout;
  logic [7:0]  sout_up, sout_dn;
  logic [2:0]  fill;
  logic        full;
  int errors = 0, checks = 0, cyc = 0;

  typedef struct {string name; logic [31:0] pout; int fill; int due;} exp_t;
  exp_t sb[$];

  shift_reg_univ #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pin(pin),
    .pout(pout), .sout_up(sout_up), .sout_dn(sout_dn), .fill(fill), .full(full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", name, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "pout", pout, e.pout);
      chk(e.name, "sout_up", {24'd0, sout_up}, {24'd0, e.pout[31:24]});
      chk(e.name, "sout_dn", {24'd0, sout_dn}, {24'd0, e.pout[7:0]});
      chk(e.name, "fill", {29'd0, fill}, e.fill);
      chk(e.name, "full", {31'd0, full}, {31'd0, e.fill == 4});
    end
  end

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [7:0] s, input logic [31:0] p);
    @(negedge clk);
    rst = r; en = e; mode = m; sin = s; pin = p;
  endtask

  task automatic expect_st(input string name, input logic [31:0] p, input int f);
    exp_t x;
    x.name = name; x.pout = p; x.fill = f; x.due = cyc + 1;
    sb.push_back(x);
  endtask

  initial begin
    drive(1, 1, 2'b11, 8'h00, 32'h12345678); expect_st("rst1", 32'hA5A5A5A5, 0);
    drive(1, 1, 2'b11, 8'h00, 32'h12345678); expect_st("rst2", 32'hA5A5A5A5, 0);
    drive(0, 1, 2'b01, 8'h01, 0); expect_st("up1", 32'hA5A5A501, 1);
    drive(0, 1, 2'b01, 8'h02, 0); expect_st("up2", 32'hA5A50102, 2);
    drive(0, 1, 2'b01, 8'h03, 0); expect_st("up3", 32'hA5010203, 3);
    drive(0, 1, 2'b01, 8'h04, 0); expect_st("up4", 32'h01020304, 4);
    drive(0, 1, 2'b01, 8'h05, 0); expect_st("up_sat", 32'h02030405, 4);
    drive(0, 1, 2'b11, 8'h00, 32'h44332211); expect_st("load", 32'h44332211, 4);
    drive(0, 1, 2'b10, 8'h55, 0); expect_st("down", 32'h55443322, 4);
    drive(1, 0, 2'b00, 8'h00, 0); expect_st("rst3", 32'hA5A5A5A5, 0);
    drive(0, 1, 2'b01, 8'h01, 0); expect_st("h_up1", 32'hA5A5A501, 1);
    drive(0, 1, 2'b01, 8'h02, 0); expect_st("h_up2", 32'hA5A50102, 2);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2'b01, 8'hEE, 0); expect_st("en_off", 32'hA5A50102, 2);
    end
    drive(0, 0, 2'b11, 8'h00, 32'hFFFFFFFF); expect_st("en_off_ld", 32'hA5A50102, 2);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 2'b00, 8'hEE, 32'hFFFFFFFF); expect_st("mode_hold", 32'hA5A50102, 2);
    end
    drive(0, 1, 2'b01, 8'h03, 0); expect_st("resume", 32'hA5010203, 3);
    drive(1, 0, 2'b00, 8'h00, 0); expect_st("rst4", 32'hA5A5A5A5, 0);
    drive(0, 1, 2'b01, 8'h11, 0); expect_st("p_up1", 32'hA5A5A511, 1);
    drive(0, 1, 2'b01, 8'h22, 0); expect_st("p_up2", 32'hA5A51122, 2);
    drive(1, 1, 2'b01, 8'h77, 0); expect_st("rst_prio", 32'hA5A5A5A5, 0);
    drive(0, 1, 2'b01, 8'h77, 0); expect_st("post_rst", 32'hA5A5A577, 1);
    drive(0, 1, 2'b11, 8'h00, 32'hDEADBEEF); expect_st("load_part", 32'hDEADBEEF, 4);
    drive(1, 0, 2'b00, 8'h00, 0); expect_st("rst5", 32'hA5A5A5A5, 0);
    drive(0, 1, 2'b01, 8'h10, 0); expect_st("mix_up", 32'hA5A5A510, 1);
    drive(0, 1, 2'b10, 8'h20, 0); expect_st("mix_dn", 32'h20A5A5A5, 2);
    drive(0, 0, 2'b00, 8'h00, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
